// File: rtl/fpmul_pipe.sv
// Pipelined IEEE-754 multiplier (DAZ/FTZ, RNE) with valid/ready stream.
// One global enable stalls every rank under output backpressure.
module fpmul_pipe #(
  parameter int EW    = 8,
  parameter int MW    = 23,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [EW+MW:0]   in_a,
  input  logic [EW+MW:0]   in_b,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [EW+MW:0]   out_p,
  output logic [TAG_W-1:0] out_tag,
  output logic [4:0]       out_flags
);

  localparam int W  = 1 + EW + MW;
  localparam int PW = 2 * (MW + 1);
  localparam int EE = EW + 2;
  localparam logic [EE-1:0] BIAS = EE'((1 << (EW - 1)) - 1);
  localparam logic [EE-2:0] EMAX = (EE - 1)'((1 << EW) - 1);

  typedef struct packed {
    logic             sgn;
    logic             nv;
    logic             inf;
    logic             zero;
    logic [PW-1:0]    prod;
    logic [EE-1:0]    e;
    logic [TAG_W-1:0] tag;
  } s1_t;

  typedef struct packed {
    logic             sgn;
    logic             nv;
    logic             inf;
    logic             zero;
    logic             ovf;
    logic             unf;
    logic             inx;
    logic [EW-1:0]    e;
    logic [MW-1:0]    f;
    logic [TAG_W-1:0] tag;
  } s2_t;

  logic             en;
  logic             v0, v1, v2;
  logic [W-1:0]     a0, b0;
  logic [TAG_W-1:0] t0;
  s1_t              s1_d, s1_q;
  s2_t              s2_d, s2_q;

  assign en       = ~out_valid | out_ready;
  assign in_ready = en;

  logic [EW-1:0] ea, eb;
  logic [MW-1:0] fa, fb;
  logic          za, zb, ia, ib, na, nb;

  assign ea = a0[W-2 -: EW];
  assign eb = b0[W-2 -: EW];
  assign fa = a0[MW-1:0];
  assign fb = b0[MW-1:0];
  assign za = (ea == '0);
  assign zb = (eb == '0);
  assign ia = (&ea) & (fa == '0);
  assign ib = (&eb) & (fb == '0);
  assign na = (&ea) & (|fa);
  assign nb = (&eb) & (|fb);

  always_comb begin
    s1_d      = '0;
    s1_d.sgn  = a0[W-1] ^ b0[W-1];
    s1_d.nv   = na | nb | (ia & zb) | (ib & za);
    s1_d.inf  = ia | ib;
    s1_d.zero = za | zb;
    s1_d.prod = PW'({1'b1, fa}) * PW'({1'b1, fb});
    s1_d.e    = EE'(ea) + EE'(eb) - BIAS;
    s1_d.tag  = t0;
  end

  logic          hi, g, st, inc;
  logic [PW-1:0] nrm;
  logic [EE-1:0] e_pre, e_fin;
  logic [MW:0]   rnd;

  // Normalise so the leading one sits at the product MSB.
  always_comb begin
    hi    = s1_q.prod[PW-1];
    nrm   = hi ? s1_q.prod : (s1_q.prod << 1);
    e_pre = hi ? (s1_q.e + EE'(1)) : s1_q.e;
    g     = nrm[PW-2-MW];
    st    = |nrm[PW-3-MW:0];
    inc   = g & (st | nrm[PW-1-MW]);
    rnd   = {1'b0, nrm[PW-2 -: MW]} + (MW + 1)'(inc);
    e_fin = e_pre + EE'(rnd[MW]);
    s2_d      = '0;
    s2_d.sgn  = s1_q.sgn;
    s2_d.nv   = s1_q.nv;
    s2_d.inf  = s1_q.inf;
    s2_d.zero = s1_q.zero;
    s2_d.ovf  = ~e_fin[EE-1] & (e_fin[EE-2:0] >= EMAX);
    s2_d.unf  = e_pre[EE-1] | (e_pre == '0);
    s2_d.inx  = g | st;
    s2_d.e    = e_fin[EW-1:0];
    s2_d.f    = rnd[MW-1:0];
    s2_d.tag  = s1_q.tag;
  end

  logic [W-1:0] r_p;
  logic [4:0]   r_f;

  always_comb begin
    r_p = {s2_q.sgn, s2_q.e, s2_q.f};
    r_f = {4'b0000, s2_q.inx};
    if (s2_q.nv) begin
      r_p = {1'b0, {EW{1'b1}}, 1'b1, {(MW - 1){1'b0}}};
      r_f = 5'b10000;
    end else if (s2_q.inf) begin
      r_p = {s2_q.sgn, {EW{1'b1}}, {MW{1'b0}}};
      r_f = 5'b00000;
    end else if (s2_q.zero) begin
      r_p = {s2_q.sgn, {(W - 1){1'b0}}};
      r_f = 5'b00000;
    end else if (s2_q.ovf) begin
      r_p = {s2_q.sgn, {EW{1'b1}}, {MW{1'b0}}};
      r_f = 5'b00101;
    end else if (s2_q.unf) begin
      r_p = {s2_q.sgn, {(W - 1){1'b0}}};
      r_f = 5'b00011;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v0        <= 1'b0;
      v1        <= 1'b0;
      v2        <= 1'b0;
      a0        <= '0;
      b0        <= '0;
      t0        <= '0;
      s1_q      <= '0;
      s2_q      <= '0;
      out_valid <= 1'b0;
      out_p     <= '0;
      out_tag   <= '0;
      out_flags <= '0;
    end else if (en) begin
      v0        <= in_valid;
      a0        <= in_a;
      b0        <= in_b;
      t0        <= in_tag;
      v1        <= v0;
      s1_q      <= s1_d;
      v2        <= v1;
      s2_q      <= s2_d;
      out_valid <= v2;
      if (v2) begin
        out_p     <= r_p;
        out_tag   <= s2_q.tag;
        out_flags <= r_f;
      end
    end
  end

endmodule

// File: tb/tb_fpmul_pipe.sv
// Scoreboard bench for fpmul_pipe: FP32 stream plus a BF16 instance.
// Expected {flags, product} come from constants or an integer RNE model.
module tb_fpmul_pipe;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_a = '0;
  logic [31:0] in_b = '0;
  logic [3:0]  in_tag = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_p;
  logic [3:0]  out_tag;
  logic [4:0]  out_flags;

  fpmul_pipe #(.EW(8), .MW(23), .TAG_W(4)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_p(out_p), .out_tag(out_tag), .out_flags(out_flags)
  );

  logic        b_in_valid = 1'b0;
  logic        b_in_ready;
  logic [15:0] b_in_a = '0;
  logic [15:0] b_in_b = '0;
  logic [3:0]  b_in_tag = '0;
  logic        b_out_valid;
  logic        b_out_ready = 1'b1;
  logic [15:0] b_out_p;
  logic [3:0]  b_out_tag;
  logic [4:0]  b_out_flags;

  fpmul_pipe #(.EW(8), .MW(7), .TAG_W(4)) dut_bf (
    .clk(clk), .rst(rst),
    .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_a(b_in_a), .in_b(b_in_b), .in_tag(b_in_tag),
    .out_valid(b_out_valid), .out_ready(b_out_ready),
    .out_p(b_out_p), .out_tag(b_out_tag), .out_flags(b_out_flags)
  );

  typedef struct {
    logic [36:0] exp;
    logic [3:0]  tag;
    int          acc;
    bit          lat;
  } ent_t;

  ent_t        sb[$];
  int          n_chk = 0;
  int          n_pass = 0;
  int          cyc = 0;
  int          seq = 0;
  bit          lat_chk = 1'b1;
  bit          done = 1'b0;
  logic [36:0] cur_exp = '0;

  task automatic chk(input string tag, input longint got, input longint exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0h, want %0h", tag, got, exp);
  endtask

  function automatic logic [36:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
    int     ea, eb, e, ef, sh;
    longint ma, mb, p, kept, rem, half;
    bit     za, zb, ia, ib, na, nb, inx, up;
    logic   s;
    ea = int'(a[30:23]);
    eb = int'(b[30:23]);
    za = (ea == 0);
    zb = (eb == 0);
    ia = (ea == 255) && (a[22:0] == 0);
    ib = (eb == 255) && (b[22:0] == 0);
    na = (ea == 255) && (a[22:0] != 0);
    nb = (eb == 255) && (b[22:0] != 0);
    s  = a[31] ^ b[31];
    if (na || nb || (ia && zb) || (ib && za)) return {5'b10000, 32'h7FC00000};
    if (ia || ib) return {5'b00000, s, 8'hFF, 23'd0};
    if (za || zb) return {5'b00000, s, 31'd0};
    ma = longint'({1'b1, a[22:0]});
    mb = longint'({1'b1, b[22:0]});
    p  = ma * mb;
    e  = ea + eb - 127;
    if (p[47]) begin
      sh = 24;
      e  = e + 1;
    end else begin
      sh = 23;
    end
    kept = p >> sh;
    rem  = p - (kept << sh);
    half = longint'(1) << (sh - 1);
    inx  = (rem != 0);
    up   = (rem > half) || ((rem == half) && kept[0]);
    kept = kept + (up ? 1 : 0);
    ef   = kept[24] ? e + 1 : e;
    if (ef >= 255) return {5'b00101, s, 8'hFF, 23'd0};
    if (e <= 0) return {5'b00011, s, 31'd0};
    return {4'b0000, inx, s, ef[7:0], kept[22:0]};
  endfunction

  function automatic logic [31:0] rnd_fp();
    logic [7:0]  e;
    logic [22:0] f;
    int          k;
    k = int'($urandom_range(0, 15));
    f = 23'($urandom);
    if (k == 0) e = 8'h00;
    else if (k == 1) e = 8'hFF;
    else if (k < 5) e = 8'($urandom_range(1, 30));
    else if (k < 8) e = 8'($urandom_range(225, 254));
    else e = 8'($urandom_range(100, 154));
    if ($urandom_range(0, 7) == 0) f = '0;
    else if ($urandom_range(0, 3) == 0) f = f & 23'h7FF000;
    return {1'($urandom), e, f};
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin : mon
    ent_t e;
    if (!rst) begin
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          chk("spurious_out", sb.size(), 1);
        end else begin
          e = sb.pop_front();
          chk("prod", {out_flags, out_p}, e.exp);
          chk("tag", out_tag, e.tag);
          if (e.lat) chk("latency", cyc - e.acc, 3);
        end
      end
      if (in_valid && in_ready)
        sb.push_back(ent_t'{cur_exp, in_tag, cyc + 1, lat_chk});
    end
  end

  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [36:0] x);
    int w;
    bit ok;
    w        = 0;
    in_a     = a;
    in_b     = b;
    cur_exp  = x;
    in_tag   = 4'(seq);
    seq++;
    in_valid = 1'b1;
    forever begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
      #1;
      if (ok) break;
      w++;
      if (w > 300) begin
        chk("accept_wait", in_ready, 1);
        break;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int w;
    w = 0;
    while (sb.size() != 0 && w < 500) begin
      @(posedge clk);
      #1;
      w++;
    end
    repeat (2) @(posedge clk);
    #1;
    chk("drain", sb.size(), 0);
  endtask

  task automatic bf_one(input logic [15:0] a, input logic [15:0] b, input logic [20:0] x);
    b_in_a     = a;
    b_in_b     = b;
    b_in_tag   = 4'hA;
    b_in_valid = 1'b1;
    @(posedge clk);
    #1;
    b_in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("bf_early", b_out_valid, 0);
    @(posedge clk);
    #1;
    chk("bf_valid", b_out_valid, 1);
    chk("bf_prod", {b_out_flags, b_out_p}, x);
    chk("bf_tag", b_out_tag, 4'hA);
  endtask

  logic [31:0] p0;
  logic [31:0] ra, rb;

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", out_valid, 0);
    chk("rst_ready", in_ready, 1);
    chk("rst_p", out_p, 0);
    chk("rst_tag", out_tag, 0);
    chk("rst_flags", out_flags, 0);
    chk("rst_bf_valid", b_out_valid, 0);
    rst = 1'b0;

    send(32'h3FC00000, 32'h40000000, {5'b00000, 32'h40400000});
    send(32'h3F800001, 32'h3FC00000, {5'b00001, 32'h3FC00002});
    send(32'h7F800000, 32'h00000000, {5'b10000, 32'h7FC00000});
    send(32'hFF800000, 32'h40000000, {5'b00000, 32'hFF800000});
    send(32'h00000001, 32'h7F000000, {5'b00000, 32'h00000000});
    send(32'h7F7FFFFF, 32'h40000000, {5'b00101, 32'h7F800000});
    send(32'h00800000, 32'h3F000000, {5'b00011, 32'h00000000});
    send(32'h3F800001, 32'h3F800001, {5'b00001, 32'h3F800002});
    send(32'h7FC12345, 32'h3F800000, {5'b10000, 32'h7FC00000});
    send(32'hBF800000, 32'h40400000, {5'b00000, 32'hC0400000});
    drain();

    lat_chk   = 1'b0;
    out_ready = 1'b0;
    fork
      begin
        for (int i = 0; i < 5; i++) begin
          ra = 32'h40000000;
          rb = 32'h3F800000 | (32'(i) << 18);
          send(ra, rb, ref_mul(ra, rb));
        end
      end
      begin : bp
        int w;
        w = 0;
        while (!out_valid && w < 50) begin
          @(posedge clk);
          #1;
          w++;
        end
        chk("bp_valid", out_valid, 1);
        p0 = out_p;
        repeat (6) begin
          @(posedge clk);
          #1;
          chk("bp_stable", {out_valid, out_p}, {1'b1, p0});
        end
        chk("bp_in_ready", in_ready, 0);
        out_ready = 1'b1;
      end
    join
    drain();

    done = 1'b0;
    fork
      begin
        for (int i = 0; i < 10000; i++) begin
          repeat ($urandom_range(0, 3) == 0 ? 1 : 0) begin
            @(posedge clk);
            #1;
          end
          ra = rnd_fp();
          rb = rnd_fp();
          send(ra, rb, ref_mul(ra, rb));
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk);
          #1;
          out_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    out_ready = 1'b1;
    drain();

    bf_one(16'h3FC0, 16'h4000, {5'b00000, 16'h4040});
    bf_one(16'h3F81, 16'h3F81, {5'b00001, 16'h3F82});
    bf_one(16'h7F7F, 16'h4000, {5'b00101, 16'h7F80});

    lat_chk = 1'b1;
    send(32'h40000000, 32'h40000000, ref_mul(32'h40000000, 32'h40000000));
    send(32'h40400000, 32'h40400000, ref_mul(32'h40400000, 32'h40400000));
    send(32'h40800000, 32'h40800000, ref_mul(32'h40800000, 32'h40800000));
    @(posedge clk);
    #1;
    chk("pre_rst_valid", out_valid, 1);
    rst = 1'b1;
    #1;
    sb.delete();
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_p", out_p, 0);
    chk("mid_rst_tag", out_tag, 0);
    chk("mid_rst_flags", out_flags, 0);
    chk("mid_rst_ready", in_ready, 1);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    send(32'h3FC00000, 32'h40000000, {5'b00000, 32'h40400000});
    drain();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/fpmul_pipe.md
# fpmul_pipe

Parametrised, pipelined IEEE-754 binary floating-point multiplier with a valid/ready stream interface, a sideband tag, and exception flags. It is the next-generation multiplier for the CUDA-core FP datapath. One instance covers FP32, FP16 or BF16 through the exponent and mantissa width parameters. It accepts one operand pair per cycle and stalls the whole pipeline under output backpressure.

## Interface
- EW, 8, exponent width (≥4)
- MW, 23, stored fraction width (≥3); FP32 = 8/23, FP16 = 5/10, BF16 = 8/7
- TAG_W, 4, sideband tag width, passed through unchanged
- clk  in  1  sole clock, rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  operand pair present
- in_ready  out  1  block accepts the pair this cycle
- in_a, in_b  in  1+EW+MW  operands {sign, exp, frac}
- in_tag  in  TAG_W  sideband tag
- out_valid  out  1  result present
- out_ready  in  1  consumer accepts the result
- out_p  out  1+EW+MW  product
- out_tag  out  TAG_W  tag of the product
- out_flags  out  5  {invalid, div0(always 0), overflow, underflow, inexact}

## Operation
- Bias = 2^(EW-1)-1. The exponent field is all-ones for Inf/NaN and zero for zero or subnormal.
- Inputs use DAZ: a zero exponent field is treated as ±0 regardless of fraction.
- Outputs use FTZ: no subnormal is ever produced.
- Sign of any non-NaN result = sign_a ^ sign_b.
- Stage 1 (S1): unpack, classify each operand (zero/inf/nan/normal), form {1,frac} and multiply to a 2·(MW+1)-bit product, compute the signed (EW+2)-bit value e = ea + eb − bias.
- Stage 2 (S2):
  - If product MSB = 1, keep the product and use e+1. Otherwise shift the product left by 1.
  - Kept fraction = the MW bits below the leading 1. G = next bit. S = OR of all remaining bits.
  - Round to nearest, ties to even: increment when G & (S | LSB).
  - A carry out of the fraction sets the fraction to 0 and increments the exponent.
  - inexact_raw = G | S.
- Stage 3 (S3): apply the special-case priority, register outputs:
  1. Either input NaN, or inf×0: out_p = {0, all-ones, 1, 0…0} (canonical quiet NaN); invalid = 1.
  2. Either input Inf: ±Inf, no flags.
  3. Either input zero: ±0, no flags.
  4. Final exponent ≥ 2^EW−1 (rounding carry included): ±Inf; overflow = 1, inexact = 1.
  5. Pre-round exponent ≤ 0: ±0; underflow = 1, inexact = 1.
  6. Otherwise the normal result; inexact = inexact_raw.
- Flags are valid only with out_valid; they are not sticky, and each result carries its own flags.
- The tag travels with its operands through all three stages.

## Timing
- Latency is 3 cycles: a pair accepted at edge N appears on out_* after edge N+3 when there is no stall. Throughput is 1 per cycle.
- Global enable: en = ~out_valid | out_ready. in_ready = en, combinational from out_valid and out_ready.
- When en = 0, all stage registers, including valids, hold. out_* stay stable while out_valid & ~out_ready (AXI-style).
- Bubbles propagate as stage-valid = 0. Data registers of invalid stages may change, but out_p, out_tag and out_flags change only on an edge where the S3 valid is loaded.
- A transfer occurs on any edge with valid & ready on that port. Accepting and emitting on the same edge is legal.
- Reset, including mid-operation: all stage valids = 0, out_valid = 0, out_p = 0, out_tag = 0, out_flags = 0. In-flight operations are discarded. in_ready = 1 during and after reset.
- Nothing is required to survive reset. The first accept is on the first edge after rst deasserts.

## Test plan
- FP32 streaming: 0x3FC00000×0x40000000 then 0x3F800001×0x3FC00000, on back-to-back cycles with out_ready = 1 → 0x40400000 with flags 0 at cycle 3, then 0x3FC00002 (tie case, rounds to even, up) with inexact = 1 at cycle 4; tags preserved.
- Specials: 0x7F800000×0x00000000 → 0x7FC00000 with invalid. 0xFF800000×0x40000000 → 0xFF800000, no flags. 0x00000001×0x7F000000 → 0x00000000 (DAZ), no flags.
- Range: 0x7F7FFFFF×0x40000000 → 0x7F800000 with overflow + inexact. 0x00800000×0x3F000000 → 0x00000000 with underflow + inexact. 0x3F800001×0x3F800001 → 0x3F800002 with inexact.
- Backpressure: issue 5 pairs with out_ready held low after the first result → out_valid stays 1 with a stable out_p; in_ready = 0 once the pipe is full. Releasing out_ready drains all 5 results in order, with no loss or duplication.
- Random valid/ready toggling: 10k random FP32 pairs, including the special classes, checked against a DAZ/FTZ RNE reference model; output order and tags must match input order.
- Parameters and reset: EW = 8, MW = 7 (BF16), 0x3FC0×0x4000 → 0x4040. Assert rst with 2 operations in flight → out_valid = 0 and all outputs 0 immediately; the next operation after release completes with latency 3.
